// File: rtl/fifo_pkg.sv
// Shared types and helpers for the Gray-pointer FIFO controller.
package fifo_pkg;

  localparam int PKG_ADDR_W = 4;
  localparam int DEPTH      = 2 ** PKG_ADDR_W;

  typedef logic [PKG_ADDR_W:0]   ptr_t;
  typedef logic [PKG_ADDR_W-1:0] addr_t;

  // Works for any pointer up to 32 bits; callers size-cast the result back down.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_gray_ptr_ctrl_gray_ptr.sv
// One Gray-coded pointer register, stepped by +1 in the binary domain.
module gray_ptr
  import fifo_pkg::*;
#(
  parameter int SIZE = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inc,
  output logic [SIZE-1:0] o_gray,
  output logic [SIZE-1:0] o_bin
);

  logic [SIZE-1:0] r_gray;
  logic [SIZE-1:0] w_bin;
  logic [SIZE-1:0] w_binNext;

  function automatic logic [SIZE-1:0] gray2bin(input logic [SIZE-1:0] g);
    logic [SIZE-1:0] b;
    b[SIZE-1] = g[SIZE-1];
    for (int i = SIZE - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign w_bin     = gray2bin(r_gray);
  assign w_binNext = w_bin + SIZE'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gray <= '0;
    end else if (i_inc) begin
      r_gray <= SIZE'(bin2gray(32'(w_binNext)));
    end
  end

  assign o_gray = r_gray;
  assign o_bin  = w_bin;

endmodule

// File: rtl/fifo_gray_ptr_ctrl.sv
// Single-clock FIFO pointer controller with Gray pointers exported for later CDC use.
// Define FIFO_CTRL_ALMOST_EN to add the almost_full / almost_empty threshold flags.
module fifo_gray_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = PKG_ADDR_W,
  parameter int AF_THRESH = 2 ** ADDR_W - 1,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
`ifdef FIFO_CTRL_ALMOST_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  logic [ADDR_W:0] w_wGray;
  logic [ADDR_W:0] w_rGray;
  logic [ADDR_W:0] w_wBin;
  logic [ADDR_W:0] w_rBin;
  logic            w_full;
  logic            w_empty;
  logic            r_overflow;
  logic            r_underflow;

  gray_ptr #(.SIZE(ADDR_W + 1)) u_wptr (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (wr_en),
    .o_gray (w_wGray),
    .o_bin  (w_wBin)
  );

  gray_ptr #(.SIZE(ADDR_W + 1)) u_rptr (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (rd_en),
    .o_gray (w_rGray),
    .o_bin  (w_rBin)
  );

  // Full in Gray: top two bits inverted, rest equal (write is one lap ahead).
  assign w_empty = (w_wGray == w_rGray);
  assign w_full  = (w_wGray == (w_rGray ^ {2'b11, {(ADDR_W - 1){1'b0}}}));

  assign wr_en     = wr_req & ~w_full;
  assign rd_en     = rd_req & ~w_empty;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = w_wBin - w_rBin;
  assign waddr     = w_wBin[ADDR_W-1:0];
  assign raddr     = w_rBin[ADDR_W-1:0];
  assign wptr_gray = w_wGray;
  assign rptr_gray = w_rGray;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_req && w_full) r_overflow <= 1'b1;
      if (rd_req && w_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;

`ifdef FIFO_CTRL_ALMOST_EN
  assign almost_full  = (count >= (ADDR_W + 1)'(AF_THRESH));
  assign almost_empty = (count <= (ADDR_W + 1)'(AE_THRESH));
`endif

endmodule

// File: tb/tb_fifo_gray_ptr_ctrl.sv
// Self-checking bench for fifo_gray_ptr_ctrl at ADDR_W=2 (depth 4).
module tb_fifo_gray_ptr_ctrl;

  localparam int AW  = 2;
  localparam int DEP = 4;

  logic          clk;
  logic          rst;
  logic          wr_req;
  logic          rd_req;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   rptr_gray;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
`ifdef FIFO_CTRL_ALMOST_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  fifo_gray_ptr_ctrl #(.ADDR_W(AW), .AF_THRESH(3), .AE_THRESH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .waddr     (waddr),
    .raddr     (raddr),
    .wptr_gray (wptr_gray),
    .rptr_gray (rptr_gray),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPassed = 0;

  // Reference model: queue of write sequence numbers plus totals of accepted accesses.
  int modelQ[$];
  int wrTotal = 0;
  int rdTotal = 0;
  bit modelOvf = 1'b0;
  bit modelUnf = 1'b0;

  typedef struct {
    bit rs;
    bit wr;
    bit rd;
    int cnt;
    bit fl;
    bit em;
    int wg;
    int rg;
    bit ovf;
    bit unf;
  } vec_t;

  vec_t vecs[13];

  function automatic int toGray(input int n);
    return n ^ (n >> 1);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual == expected) nPassed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // One cycle: drive at negedge, check strobes before the edge, check state after it.
  task automatic applyStimulus(input bit rs, input bit wr, input bit rd);
    bit expWr;
    bit expRd;
    int occ;
    logic [AW:0] prevWg;
    logic [AW:0] prevRg;
    @(negedge clk);
    rst    = rs;
    wr_req = wr;
    rd_req = rd;
    #1;
    occ   = modelQ.size();
    expWr = wr && (occ != DEP);
    expRd = rd && (occ != 0);
    if (!rs) begin
      checkOutput("wr_en", int'(wr_en), int'(expWr));
      checkOutput("rd_en", int'(rd_en), int'(expRd));
      if (expWr) checkOutput("waddr", int'(waddr), wrTotal % DEP);
      if (expRd) checkOutput("raddr", int'(raddr), modelQ[0] % DEP);
    end
    prevWg = wptr_gray;
    prevRg = rptr_gray;
    @(posedge clk);
    #1;
    if (rs) begin
      modelQ.delete();
      wrTotal  = 0;
      rdTotal  = 0;
      modelOvf = 1'b0;
      modelUnf = 1'b0;
    end else begin
      if (wr && occ == DEP) modelOvf = 1'b1;
      if (rd && occ == 0) modelUnf = 1'b1;
      if (expRd) begin
        void'(modelQ.pop_front());
        rdTotal++;
      end
      if (expWr) begin
        modelQ.push_back(wrTotal);
        wrTotal++;
      end
      if (expWr) checkOutput("wgray_onebit", $countones(wptr_gray ^ prevWg), 1);
      if (expRd) checkOutput("rgray_onebit", $countones(rptr_gray ^ prevRg), 1);
    end
    checkOutput("count", int'(count), modelQ.size());
    checkOutput("full", int'(full), int'(modelQ.size() == DEP));
    checkOutput("empty", int'(empty), int'(modelQ.size() == 0));
    checkOutput("wptr_gray", int'(wptr_gray), toGray(wrTotal % (2 * DEP)));
    checkOutput("rptr_gray", int'(rptr_gray), toGray(rdTotal % (2 * DEP)));
    checkOutput("overflow", int'(overflow), int'(modelOvf));
    checkOutput("underflow", int'(underflow), int'(modelUnf));
`ifdef FIFO_CTRL_ALMOST_EN
    checkOutput("almost_full", int'(almost_full), int'(modelQ.size() >= 3));
    checkOutput("almost_empty", int'(almost_empty), int'(modelQ.size() <= 1));
`endif
  endtask

  initial begin
    rst    = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;

    // rs wr rd | count full empty wgray rgray ovf unf
    vecs[0]  = '{1, 1, 0, 0, 0, 1, 3'b000, 3'b000, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 0, 1, 3'b000, 3'b000, 0, 0};
    vecs[2]  = '{0, 1, 0, 1, 0, 0, 3'b001, 3'b000, 0, 0};
    vecs[3]  = '{0, 1, 0, 2, 0, 0, 3'b011, 3'b000, 0, 0};
    vecs[4]  = '{0, 1, 0, 3, 0, 0, 3'b010, 3'b000, 0, 0};
    vecs[5]  = '{0, 1, 0, 4, 1, 0, 3'b110, 3'b000, 0, 0};
    vecs[6]  = '{0, 1, 0, 4, 1, 0, 3'b110, 3'b000, 1, 0};
    vecs[7]  = '{0, 0, 1, 3, 0, 0, 3'b110, 3'b001, 1, 0};
    vecs[8]  = '{0, 0, 1, 2, 0, 0, 3'b110, 3'b011, 1, 0};
    vecs[9]  = '{0, 0, 1, 1, 0, 0, 3'b110, 3'b010, 1, 0};
    vecs[10] = '{0, 0, 1, 0, 0, 1, 3'b110, 3'b110, 1, 0};
    vecs[11] = '{0, 0, 1, 0, 0, 1, 3'b110, 3'b110, 1, 1};
    vecs[12] = '{1, 0, 0, 0, 0, 1, 3'b000, 3'b000, 0, 0};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rs, vecs[i].wr, vecs[i].rd);
      checkOutput($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
      checkOutput($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].fl));
      checkOutput($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].em));
      checkOutput($sformatf("vec%0d_wgray", i), int'(wptr_gray), vecs[i].wg);
      checkOutput($sformatf("vec%0d_rgray", i), int'(rptr_gray), vecs[i].rg);
      checkOutput($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].ovf));
      checkOutput($sformatf("vec%0d_unf", i), int'(underflow), int'(vecs[i].unf));
    end

    // Simultaneous access at empty, at count=2 and at full.
    applyStimulus(0, 1, 1);
    checkOutput("both_at_empty_count", int'(count), 1);
    checkOutput("both_at_empty_unf", int'(underflow), 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    checkOutput("both_at_two_count", int'(count), 2);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    checkOutput("both_at_full_count", int'(count), 3);
    checkOutput("both_at_full_ovf", int'(overflow), 1);

    // Wrap: 20 write/read pairs walk both pointers through 100 -> 000 more than once.
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 1);
    end
    checkOutput("wrap_wgray", int'(wptr_gray), toGray(20 % 8));
    checkOutput("wrap_empty", int'(empty), 1);
    checkOutput("wrap_unf", int'(underflow), 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
